// File: rtl/sb_arm_cmd_issuer.sv
// rtl/sb_arm_cmd_issuer.sv - pick/place job initiator for the arm servo controller.
// Optional WAIT_DONE abort counter is built only when SB_ARM_TIMEOUT_EN is defined.
module sb_arm_cmd_issuer #(
   parameter int unsigned TIMEOUT_CYCLES = 300_000_000,
   parameter int unsigned GAP_CYCLES     = 1000,
   parameter logic [5:0]  PICK_CODE      = 6'd0,
   parameter logic [5:0]  PLACE_CODE     = 6'd1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic       req_type,
   output logic       req_ready,
   output logic       arm_start,
   output logic [5:0] arm_movement,
   input  logic [1:0] arm_done,
   output logic       resp_valid,
   output logic [1:0] resp_code,
   output logic       holding,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_DONE,
      S_RELEASE,
      S_RESP
   } state_t;

   localparam logic [1:0]  CODE_OK       = 2'd0;
   localparam logic [1:0]  CODE_TIMEOUT  = 2'd1;
   localparam logic [1:0]  CODE_BAD_DONE = 2'd2;
   localparam logic [1:0]  CODE_REJECTED = 2'd3;
   localparam logic [15:0] GAP_LAST      = 16'(GAP_CYCLES - 1);

   state_t      state;
   state_t      next_state;
   logic        job_type;
   logic [1:0]  code_q;
   logic [1:0]  next_code;
   logic [1:0]  blank_cnt;
   logic [15:0] gap_cnt;

   logic accept;
   logic illegal;
   logic blank_done;
   logic done_hit;
   logic done_ok;
   logic tmo_hit;
   logic gap_last;

   assign accept     = (state == S_IDLE) && req_valid && req_ready;
   assign illegal    = req_type ? !holding : holding;
   assign blank_done = (blank_cnt == 2'd2);
   assign done_hit   = blank_done && (arm_done != 2'd0);
   assign done_ok    = done_hit && (arm_done == (job_type ? 2'd2 : 2'd1));
   assign gap_last   = (gap_cnt == GAP_LAST);

`ifdef SB_ARM_TIMEOUT_EN
   logic [31:0] tmo_cnt;

   assign tmo_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Saturates at the terminal count; leaving WAIT_DONE makes further counting moot.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt <= 32'd0;
      end else if (state == S_ISSUE) begin
         tmo_cnt <= 32'd0;
      end else if ((state == S_WAIT_DONE) && !tmo_hit) begin
         tmo_cnt <= tmo_cnt + 32'd1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      next_state = state;
      next_code  = code_q;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (illegal) begin
                  next_state = S_RESP;
                  next_code  = CODE_REJECTED;
               end else begin
                  next_state = S_ISSUE;
               end
            end
         end
         S_ISSUE: next_state = S_WAIT_DONE;
         S_WAIT_DONE: begin
            // A valid done wins over a simultaneous timeout terminal count.
            if (done_hit) begin
               next_state = S_RELEASE;
               next_code  = done_ok ? CODE_OK : CODE_BAD_DONE;
            end else if (tmo_hit) begin
               next_state = S_RELEASE;
               next_code  = CODE_TIMEOUT;
            end
         end
         S_RELEASE: begin
            if (gap_last) begin
               next_state = S_RESP;
            end
         end
         S_RESP:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         job_type     <= 1'b0;
         code_q       <= CODE_OK;
         blank_cnt    <= 2'd0;
         gap_cnt      <= 16'd0;
         req_ready    <= 1'b1;
         busy         <= 1'b0;
         arm_start    <= 1'b0;
         arm_movement <= 6'd0;
         resp_valid   <= 1'b0;
         resp_code    <= CODE_OK;
         holding      <= 1'b0;
      end else begin
         state     <= next_state;
         code_q    <= next_code;
         req_ready <= (state == S_IDLE) && !accept;
         busy      <= !((state == S_IDLE) && !accept);
         arm_start <= (next_state == S_WAIT_DONE);

         if (accept) begin
            job_type <= req_type;
         end

         if (state == S_ISSUE) begin
            arm_movement <= job_type ? PLACE_CODE : PICK_CODE;
         end

         // Blank window hides a stale done left over from the previous job.
         if (state == S_ISSUE) begin
            blank_cnt <= 2'd0;
         end else if ((state == S_WAIT_DONE) && !blank_done) begin
            blank_cnt <= blank_cnt + 2'd1;
         end

         if ((state == S_WAIT_DONE) && (next_state == S_RELEASE)) begin
            gap_cnt <= 16'd0;
         end else if ((state == S_RELEASE) && !gap_last) begin
            gap_cnt <= gap_cnt + 16'd1;
         end

         resp_valid <= (state == S_RESP);
         if (state == S_RESP) begin
            resp_code <= code_q;
            if (code_q == CODE_OK) begin
               holding <= !job_type;
            end
         end
      end
   end

endmodule

// File: tb/tb_sb_arm_cmd_issuer.sv
// tb/tb_sb_arm_cmd_issuer.sv - randomized scoreboard bench for sb_arm_cmd_issuer.
module tb_sb_arm_cmd_issuer;

   localparam int T = 100;
   localparam int G = 4;
`ifdef SB_ARM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_type;
   logic       req_ready;
   logic       arm_start;
   logic [5:0] arm_movement;
   logic [1:0] arm_done;
   logic       resp_valid;
   logic [1:0] resp_code;
   logic       holding;
   logic       busy;

   sb_arm_cmd_issuer #(
      .TIMEOUT_CYCLES(T),
      .GAP_CYCLES    (G),
      .PICK_CODE     (6'd0),
      .PLACE_CODE    (6'd1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_type    (req_type),
      .req_ready   (req_ready),
      .arm_start   (arm_start),
      .arm_movement(arm_movement),
      .arm_done    (arm_done),
      .resp_valid  (resp_valid),
      .resp_code   (resp_code),
      .holding     (holding),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] code;
      logic       hold;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   model_hold = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every response pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("resp_unexpected", resp_valid, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("resp_code", resp_code, e.code);
            check("resp_holding", holding, e.hold);
         end
      end
   end

   task automatic wait_ready();
      int w = 0;
      while (req_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) check("ready_wait_bound", req_ready, 1);
   endtask

   // One job: stale done for the first 2 WAIT_DONE cycles, d cycles of 0, then v.
   task automatic run_job(input bit typ, input logic [1:0] stale, input int d, input logic [1:0] v);
      bit   bad;
      int   term;
      int   c;
      int   n;
      bit   tmo;
      logic [1:0] code;
      wait_ready();
      bad = typ ? !model_hold : model_hold;
      if (bad) begin
         sb_q.push_back('{2'd3, model_hold});
      end else begin
         term = 2 + d;
         tmo  = TO_EN && (term > T - 1);
         if (tmo) term = T - 1;
         code = tmo ? 2'd1 : ((v == (typ ? 2'd2 : 2'd1)) ? 2'd0 : 2'd2);
         if (code == 2'd0) model_hold = !typ;
         sb_q.push_back('{code, model_hold});
      end
      req_valid = 1'b1;
      req_type  = typ;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_type  = 1'($urandom);
      if (bad) begin
         @(negedge clk);
         check("rej_resp_n1", resp_valid, 1);
         check("rej_no_start", arm_start, 0);
         @(negedge clk);
         check("rej_ready_n2", req_ready, 1);
      end else begin
         check("start_low_issue", arm_start, 0);
         @(negedge clk);
         check("start_at_n1", arm_start, 1);
         check("busy_job", busy, 1);
         c = 0;
         forever begin
            arm_done = (c < 2) ? stale : ((c >= 2 + d) ? v : 2'd0);
            @(negedge clk);
            if (arm_start !== 1'b1 || c > 2000) break;
            c++;
         end
         check("term_cycle", c, term);
         check("movement", arm_movement, typ ? 6'd1 : 6'd0);
         arm_done = 2'd0;
         n = 0;
         while (resp_valid !== 1'b1 && n < G + 20) begin
            @(negedge clk);
            n++;
         end
         check("resp_gap", n, G + 1);
         check("start_low_gap", arm_start, 0);
      end
   endtask

   task automatic reset_mid_job();
      int w;
      wait_ready();
      req_valid = 1'b1;
      req_type  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      w = 0;
      while (arm_start !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_hold = 1'b0;
      check("rst_mid_start", arm_start, 0);
      check("rst_mid_holding", holding, 0);
      check("rst_mid_ready", req_ready, 1);
      check("rst_mid_busy", busy, 0);
      repeat (G + 10) @(negedge clk);
   endtask

   initial begin
      int w;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_type  = 1'b0;
      arm_done  = 2'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_ready", req_ready, 1);
      check("rst_start", arm_start, 0);
      check("rst_movement", arm_movement, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_code", resp_code, 0);
      check("rst_holding", holding, 0);
      check("rst_busy", busy, 0);

      run_job(1'b0, 2'd0, 18, 2'd1);
      run_job(1'b1, 2'd0, 5, 2'd2);
      run_job(1'b1, 2'd0, 0, 2'd2);
      run_job(1'b0, 2'd0, 3, 2'd2);
      run_job(1'b0, 2'd1, 200, 2'd1);
      run_job(1'b0, 2'd2, 0, 2'd1);

      for (int i = 0; i < 30; i++) begin
         run_job(1'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 12),
                 2'($urandom_range(1, 3)));
      end

      if (!model_hold) run_job(1'b0, 2'd0, 1, 2'd1);
      reset_mid_job();
      run_job(1'b0, 2'd3, 2, 2'd1);
      run_job(1'b1, 2'd0, 4, 2'd2);

      w = 0;
      while (sb_q.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("scoreboard_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
